cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 RUN  input  1  level; 1 = free-running execution.
REQ-005 STEP  input  1  single-cycle pulse; execute exactly one instruction from IDLE.
REQ-006 MEM_RDY  input  1  program memory data valid; gates instruction fetch.
REQ-007 EXTRA  input  1  from decode; instruction needs EXEC2, sampled only in EXEC1.
REQ-008 IR  input  4  current opcode; STP = 4'b0111.
REQ-009 FETCH, EXEC1, EXEC2  output  1 each  one-hot phase strobes to decode.
REQ-010 IR_LOAD  output  1  load instruction register.
REQ-011 HALTED  output  1  high in HALT.
REQ-012 BUSY  output  1  high in FETCH, EXEC1 or EXEC2.
REQ-013 INSTR_CNT  output  CNT_W  retired-instruction count.

Function
REQ-014 Five states: IDLE, FETCH, EXEC1, EXEC2, HALT.
REQ-015 FETCH, EXEC1 and EXEC2 are registered, mutually exclusive and all 0 in IDLE and HALT.
REQ-016 IDLE, RUN=1 -> FETCH with step_mode=0.
REQ-017 IDLE, RUN=0, STEP=1 -> FETCH with step_mode=1.
REQ-018 IDLE, RUN=1 and STEP=1 simultaneously -> RUN wins, step_mode=0.
REQ-019 STEP is ignored outside IDLE, and is not queued.
REQ-020 FETCH, MEM_RDY=0 -> stay in FETCH; wait is unbounded.
REQ-021 FETCH, MEM_RDY=1 -> IR_LOAD=1 combinationally in that cycle, then EXEC1.
REQ-022 IR_LOAD is 0 in every other state and cycle.
REQ-023 EXEC1, IR=STP -> HALT; INSTR_CNT is not incremented.
REQ-024 EXEC1, IR not STP, EXTRA=1 -> EXEC2.
REQ-025 EXEC1, IR not STP, EXTRA=0 -> end-of-instruction.
REQ-026 EXEC2 -> end-of-instruction unconditionally, one cycle.
REQ-027 End-of-instruction: INSTR_CNT increments by 1, wrapping from 2^CNT_W-1 to 0.
REQ-028 End-of-instruction next state: IDLE if step_mode=1 or RUN=0, else FETCH.
REQ-029 RUN dropping mid-instruction does not abort; the current instruction completes first.
REQ-030 HALT is sticky: exited only by RESET; RUN and STEP are ignored.
REQ-031 Latency without waits: 2 cycles per instruction when EXTRA=0, 3 when EXTRA=1.

Reset
REQ-032 RESET=1 at an edge -> state IDLE, step_mode=0, INSTR_CNT=0, all outputs 0.
REQ-033 RESET overrides every transition, including mid-FETCH wait and HALT.

Structure
REQ-034 Shared package cpu_pkg holds the state enum and opcode constants (OP_LDA..OP_ASR, OP_STP).
REQ-035 The counter is sub-module instr_counter (CNT_W, clear, inc, value).
REQ-036 Next-state logic is a single registered FSM; there are no other sub-modules.

Verification
REQ-037 Reset, RUN=1, MEM_RDY=1, IR=ADD (EXTRA=1) x3 -> FETCH/EXEC1/EXEC2 repeats every 3 cycles; INSTR_CNT=3 after 9 cycles.
REQ-038 RUN=0, STEP pulse, IR=LSR (EXTRA=0) -> exactly one FETCH,EXEC1; returns to IDLE; INSTR_CNT=1; a second STEP gives INSTR_CNT=2.
REQ-039 MEM_RDY held 0 for 5 cycles in FETCH -> FETCH stays high for 6 cycles; IR_LOAD is a single pulse on the MEM_RDY=1 cycle.
REQ-040 IR=STP in EXEC1 -> HALTED=1 next cycle; INSTR_CNT unchanged; RUN/STEP toggling has no effect; RESET -> IDLE, INSTR_CNT=0.
REQ-041 CNT_W=4, 16 instructions retired -> INSTR_CNT wraps to 0; RUN and STEP asserted together in IDLE -> continuous run.
REQ-042 RESET asserted during EXEC2 -> all outputs 0 next cycle; no count increment.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer state encoding and opcode constants shared by the CPU control path.
package cpu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT} state_t;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_LSR = 4'b0101;
  localparam logic [3:0] OP_ASR = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
endpackage

// File: rtl/instr_counter.sv
// instr_counter: wrapping retired-instruction counter with synchronous clear.
module instr_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value
);
  always_ff @(posedge clk) begin
    if (clear) value <= '0;
    else if (inc) value <= value + CNT_W'(1);
  end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute phase sequencer with run, single-step and sticky halt.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             mem_rdy,
  input  logic             extra,
  input  logic [3:0]       ir,
  output logic             fetch,
  output logic             exec1,
  output logic             exec2,
  output logic             ir_load,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] instr_cnt
);
  state_t state, state_n;
  logic step_mode, step_mode_n, eoi;
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      step_mode <= 1'b0;
    end else begin
      state     <= state_n;
      step_mode <= step_mode_n;
    end
  end
  always_comb begin
    state_n     = state;
    step_mode_n = step_mode;
    eoi         = (state == S_EXEC2) || (state == S_EXEC1 && ir != OP_STP && !extra);
    ir_load     = (state == S_FETCH) && mem_rdy;
    if (state == S_IDLE && (run || step)) begin
      state_n     = S_FETCH;
      step_mode_n = !run;
    end
    if (ir_load) state_n = S_EXEC1;
    if (state == S_EXEC1) state_n = (ir == OP_STP) ? S_HALT : S_EXEC2;
    // a dropped run or single-step request parks in IDLE only once the instruction retires
    if (eoi) state_n = (step_mode || !run) ? S_IDLE : S_FETCH;
  end
  assign fetch  = state == S_FETCH;
  assign exec1  = state == S_EXEC1;
  assign exec2  = state == S_EXEC2;
  assign halted = state == S_HALT;
  assign busy   = fetch || exec1 || exec2;
  instr_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (eoi),
    .value (instr_cnt)
  );
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of phase sequencing, stepping, waits, halt, wrap and reset.
module tb_cpu_sequencer;
  import cpu_pkg::*;
  logic clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0, mem_rdy = 1'b0, extra = 1'b0;
  logic [3:0] ir = OP_LDA;
  logic fetch, exec1, exec2, ir_load, halted, busy;
  logic [15:0] instr_cnt;
  logic fetch4, exec14, exec24, ir_load4, halted4, busy4;
  logic [3:0] instr_cnt4;
  int n_chk = 0, n_pass = 0;
  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .mem_rdy(mem_rdy), .extra(extra), .ir(ir),
    .fetch(fetch), .exec1(exec1), .exec2(exec2), .ir_load(ir_load), .halted(halted), .busy(busy),
    .instr_cnt(instr_cnt)
  );
  cpu_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .run(run), .step(step), .mem_rdy(mem_rdy), .extra(extra), .ir(ir),
    .fetch(fetch4), .exec1(exec14), .exec2(exec24), .ir_load(ir_load4), .halted(halted4), .busy(busy4),
    .instr_cnt(instr_cnt4)
  );
  always #5 clk = ~clk;
  wire [5:0] outs  = {fetch, exec1, exec2, ir_load, halted, busy};
  wire [5:0] outs4 = {fetch4, exec14, exec24, ir_load4, halted4, busy4};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    tick(2);
    chk("reset outs", 32'(outs), 32'h00);
    chk("reset outs4", 32'(outs4), 32'h00);
    chk("reset cnt", 32'(instr_cnt), 0);
    reset = 1'b0;
    // free run, three ADD instructions with EXEC2
    run = 1'b1; mem_rdy = 1'b1; ir = OP_ADD; extra = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run fetch", 32'(outs), 32'b100101);
      tick();
      chk("run exec1", 32'(outs), 32'b010001);
      tick();
      chk("run exec2", 32'(outs), 32'b001001);
    end
    tick();
    chk("run 9cyc fetch", 32'(fetch), 1);
    chk("run 9cyc cnt", 32'(instr_cnt), 3);
    run = 1'b0;
    tick(2);
    chk("run drop completes", 32'(exec2), 1);
    tick();
    chk("run drop idle", 32'(outs), 32'h00);
    chk("run drop cnt", 32'(instr_cnt), 4);
    // single step
    step = 1'b1; ir = OP_LSR; extra = 1'b0;
    tick();
    step = 1'b0;
    chk("step fetch", 32'(outs), 32'b100101);
    tick();
    chk("step exec1", 32'(outs), 32'b010001);
    tick();
    chk("step idle", 32'(outs), 32'h00);
    chk("step cnt", 32'(instr_cnt), 5);
    tick();
    chk("step stays idle", 32'(outs), 32'h00);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    run = 1'b1;
    tick();
    chk("step2 idle despite run", 32'(outs), 32'h00);
    chk("step2 cnt", 32'(instr_cnt), 6);
    run = 1'b0;
    // memory wait
    run = 1'b1; mem_rdy = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wait fetch", 32'({fetch, ir_load}), 32'b10);
      tick();
    end
    mem_rdy = 1'b1;
    #1;
    chk("wait ir_load", 32'({fetch, ir_load}), 32'b11);
    run = 1'b0;
    tick();
    chk("wait exec1 no load", 32'({exec1, ir_load}), 32'b10);
    tick();
    chk("wait cnt", 32'(instr_cnt), 7);
    // halt
    run = 1'b1; ir = OP_STP; extra = 1'b1;
    tick(2);
    chk("stp exec1", 32'(exec1), 1);
    tick();
    chk("halt outs", 32'(outs), 32'b000010);
    chk("halt cnt", 32'(instr_cnt), 7);
    run = 1'b0; step = 1'b1;
    tick();
    run = 1'b1; step = 1'b0;
    tick();
    chk("halt sticky", 32'(outs), 32'b000010);
    chk("halt sticky cnt", 32'(instr_cnt), 7);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    chk("halt reset outs", 32'(outs), 32'h00);
    chk("halt reset cnt", 32'(instr_cnt), 0);
    // run+step together, wrap of the 4-bit counter
    run = 1'b1; step = 1'b1; ir = OP_LSR; extra = 1'b0;
    tick();
    step = 1'b0;
    tick(30);
    chk("wrap cnt4 15", 32'(instr_cnt4), 15);
    tick(2);
    chk("wrap cnt4 0", 32'(instr_cnt4), 0);
    chk("wrap cnt16", 32'(instr_cnt), 16);
    chk("wrap continuous", 32'(outs4), 32'b100101);
    // reset in EXEC2
    ir = OP_ADD; extra = 1'b1;
    tick(2);
    chk("pre-reset exec2", 32'(exec2), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    chk("exec2 reset outs", 32'(outs), 32'h00);
    chk("exec2 reset cnt", 32'(instr_cnt), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
